// File: rtl/ime_pkg.sv
// Shared types and constants for the frame accumulator.
// The saturation-limit helpers return a SAT_W_MAX-wide pattern. Callers
// size-cast it down to their own accumulator width.
package ime_pkg;

  localparam int W_ACC_DEF = 32;
  localparam int W_SUM_DEF = 48;
  localparam int K_MAX_DEF = 4096;
  localparam int SAT_W_MAX = 64;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    HOLD = 2'd2
  } accum_state_e;

  // Largest signed value representable in w bits (low w bits of the result).
  function automatic logic [SAT_W_MAX-1:0] sat_max_f(input int unsigned w);
    return (64'd1 << (w - 32'd1)) - 64'd1;
  endfunction

  // Smallest signed value representable in w bits (low w bits of the result).
  function automatic logic [SAT_W_MAX-1:0] sat_min_f(input int unsigned w);
    return ~sat_max_f(w);
  endfunction

endpackage

// File: rtl/ime_accum_if.sv
// Beat-in / result-out bundle of the frame accumulator, including the
// synchronous frame abort.
interface ime_accum_if
  import ime_pkg::*;
#(
  parameter int W_ACC = W_ACC_DEF,
  parameter int W_SUM = W_SUM_DEF,
  parameter int K_MAX = K_MAX_DEF
);
  localparam int W_CNT = $clog2(K_MAX + 1);

  logic                    in_valid;
  logic                    in_ready;
  logic signed [W_ACC-1:0] in_partial_acc;
  logic [7:0]              in_tuser;
  logic                    in_last;
  logic                    in_poison;
  logic                    clear;
  logic                    out_valid;
  logic                    out_ready;
  logic signed [W_SUM-1:0] out_result;
  logic [W_CNT-1:0]        out_count;
  logic [7:0]              out_tuser;
  logic                    out_poison;
  logic                    out_overflow;
  logic                    out_k_exceeded;

  modport master (
    output in_valid, in_partial_acc, in_tuser, in_last, in_poison, clear, out_ready,
    input  in_ready, out_valid, out_result, out_count, out_tuser, out_poison,
           out_overflow, out_k_exceeded
  );

  modport slave (
    input  in_valid, in_partial_acc, in_tuser, in_last, in_poison, clear, out_ready,
    output in_ready, out_valid, out_result, out_count, out_tuser, out_poison,
           out_overflow, out_k_exceeded
  );
endinterface

// File: rtl/ime_sat_add.sv
// Combinational signed saturating adder. The result clamps to the W_SUM-bit
// signed range, and overflow flags that a clamp happened.
module ime_sat_add
  import ime_pkg::*;
#(
  parameter int W_SUM = W_SUM_DEF
) (
  input  logic signed [W_SUM-1:0] a,
  input  logic signed [W_SUM-1:0] b,
  output logic signed [W_SUM-1:0] sum,
  output logic                    overflow
);
  logic [W_SUM:0] wide_s;

  // One guard bit exposes signed overflow as a disagreement of the top two bits.
  always_comb begin
    wide_s = {a[W_SUM-1], a} + {b[W_SUM-1], b};
    if ((wide_s[W_SUM] == 1'b0) && (wide_s[W_SUM-1] == 1'b1)) begin
      sum      = W_SUM'(sat_max_f(W_SUM));
      overflow = 1'b1;
    end else if ((wide_s[W_SUM] == 1'b1) && (wide_s[W_SUM-1] == 1'b0)) begin
      sum      = W_SUM'(sat_min_f(W_SUM));
      overflow = 1'b1;
    end else begin
      sum      = wide_s[W_SUM-1:0];
      overflow = 1'b0;
    end
  end
endmodule

// File: rtl/ime_accum.sv
// Frame accumulator. It sums the signed partials of one frame with saturation,
// counts the beats, and presents one registered result per frame. A poisoned
// frame presents a zero result with out_poison set.
module ime_accum
  import ime_pkg::*;
#(
  parameter int W_ACC = W_ACC_DEF,
  parameter int W_SUM = W_SUM_DEF,
  parameter int K_MAX = K_MAX_DEF
) (
  input logic        clk,
  input logic        rst_n,
  ime_accum_if.slave bus
);
  localparam int               W_CNT   = $clog2(K_MAX + 1);
  localparam logic [W_CNT-1:0] K_MAX_C = W_CNT'(K_MAX);

  accum_state_e            state_r, state_next_s;
  logic signed [W_ACC-1:0] part_s;
  logic signed [W_SUM-1:0] part_ext_s, add_sum_s, sum_r, sum_next_s, result_next_s;
  logic                    add_ovf_s;
  logic [W_CNT-1:0]        count_r, count_next_s;
  logic [7:0]              tag_r, tag_next_s;
  logic                    poison_r, poison_next_s, ovf_r, ovf_next_s, kex_r, kex_next_s;
  logic                    in_ready_r, in_ready_next_s, out_valid_r, out_valid_next_s;
  logic                    beat_s, hs_s;
  logic signed [W_SUM-1:0] out_result_r;
  logic [W_CNT-1:0]        out_count_r;
  logic [7:0]              out_tuser_r;
  logic                    out_poison_r, out_overflow_r, out_kex_r;

  assign part_s     = bus.in_partial_acc;
  assign part_ext_s = W_SUM'(part_s);
  assign beat_s     = bus.in_valid && in_ready_r;
  assign hs_s       = out_valid_r && bus.out_ready;

  ime_sat_add #(.W_SUM(W_SUM)) u_sat_add (
    .a        (sum_r),
    .b        (part_ext_s),
    .sum      (add_sum_s),
    .overflow (add_ovf_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next state: clear wins over any beat or result handshake.
  always_comb begin
    state_next_s = state_r;
    if (bus.clear) begin
      state_next_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (beat_s) state_next_s = bus.in_last ? HOLD : ACC;
                 else        state_next_s = IDLE;
        ACC:     if (beat_s && bus.in_last) state_next_s = HOLD;
                 else                       state_next_s = ACC;
        HOLD:    if (hs_s) state_next_s = IDLE;
                 else      state_next_s = HOLD;
        default: state_next_s = IDLE;
      endcase
    end
  end

  // Frame datapath: the first beat seeds, later beats accumulate, abort or handshake zeroes.
  always_comb begin
    sum_next_s    = sum_r;
    count_next_s  = count_r;
    tag_next_s    = tag_r;
    poison_next_s = poison_r;
    ovf_next_s    = ovf_r;
    kex_next_s    = kex_r;
    if (bus.clear || hs_s) begin
      sum_next_s    = {W_SUM{1'b0}};
      count_next_s  = {W_CNT{1'b0}};
      tag_next_s    = 8'h00;
      poison_next_s = 1'b0;
      ovf_next_s    = 1'b0;
      kex_next_s    = 1'b0;
    end else if (beat_s && (state_r == IDLE)) begin
      sum_next_s    = part_ext_s;
      count_next_s  = W_CNT'(1);
      tag_next_s    = bus.in_tuser;
      poison_next_s = bus.in_poison;
      ovf_next_s    = 1'b0;
      kex_next_s    = 1'b0;
    end else if (beat_s) begin
      sum_next_s = add_sum_s;
      ovf_next_s = ovf_r | add_ovf_s;
      if (count_r < K_MAX_C) begin
        count_next_s  = count_r + W_CNT'(1);
        poison_next_s = poison_r | bus.in_poison | (bus.in_tuser != tag_r);
      end else begin
        // The count stays pinned at K_MAX. Excess beats are absorbed but fail the frame.
        count_next_s  = count_r;
        kex_next_s    = 1'b1;
        poison_next_s = 1'b1;
      end
    end else begin
      sum_next_s = sum_r;
    end
  end

  // Output decode from the next state, so every handshake output is a flop.
  always_comb begin
    in_ready_next_s  = (state_next_s != HOLD);
    out_valid_next_s = (state_next_s == HOLD);
    if (poison_next_s) begin
      result_next_s = {W_SUM{1'b0}};
    end else begin
      result_next_s = sum_next_s;
    end
  end

  // Datapath and output registers. Outputs read zero whenever no result is presented.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_r          <= {W_SUM{1'b0}};
      count_r        <= {W_CNT{1'b0}};
      tag_r          <= 8'h00;
      poison_r       <= 1'b0;
      ovf_r          <= 1'b0;
      kex_r          <= 1'b0;
      in_ready_r     <= 1'b0;
      out_valid_r    <= 1'b0;
      out_result_r   <= {W_SUM{1'b0}};
      out_count_r    <= {W_CNT{1'b0}};
      out_tuser_r    <= 8'h00;
      out_poison_r   <= 1'b0;
      out_overflow_r <= 1'b0;
      out_kex_r      <= 1'b0;
    end else begin
      sum_r       <= sum_next_s;
      count_r     <= count_next_s;
      tag_r       <= tag_next_s;
      poison_r    <= poison_next_s;
      ovf_r       <= ovf_next_s;
      kex_r       <= kex_next_s;
      in_ready_r  <= in_ready_next_s;
      out_valid_r <= out_valid_next_s;
      if (out_valid_next_s) begin
        out_result_r   <= result_next_s;
        out_count_r    <= count_next_s;
        out_tuser_r    <= tag_next_s;
        out_poison_r   <= poison_next_s;
        out_overflow_r <= ovf_next_s;
        out_kex_r      <= kex_next_s;
      end else begin
        out_result_r   <= {W_SUM{1'b0}};
        out_count_r    <= {W_CNT{1'b0}};
        out_tuser_r    <= 8'h00;
        out_poison_r   <= 1'b0;
        out_overflow_r <= 1'b0;
        out_kex_r      <= 1'b0;
      end
    end
  end

  assign bus.in_ready       = in_ready_r;
  assign bus.out_valid      = out_valid_r;
  assign bus.out_result     = out_result_r;
  assign bus.out_count      = out_count_r;
  assign bus.out_tuser      = out_tuser_r;
  assign bus.out_poison     = out_poison_r;
  assign bus.out_overflow   = out_overflow_r;
  assign bus.out_k_exceeded = out_kex_r;
endmodule

// File: tb/tb_ime_accum.sv
// Bench for ime_accum. Three instances (default, W_SUM=32, K_MAX=4) receive
// identical stimulus and run in lockstep. Each instance is checked against a
// frame-level arithmetic model that uses its own parameters.
module tb_ime_accum;
  typedef struct packed {
    logic        vld;
    logic [63:0] res;
    logic [31:0] cnt;
    logic [7:0]  tg;
    logic        pz;
    logic        ov;
    logic        kx;
  } res_t;

  localparam int WS[3] = '{48, 32, 48};
  localparam int KM[3] = '{4096, 4096, 4};

  logic clk, rst_n;
  logic drv_valid, drv_last, drv_poison, drv_clear, drv_ready;
  logic [31:0] drv_part;
  logic [7:0]  drv_tuser;

  int   n_cmp = 0;
  int   n_fail = 0;
  int   bv[$];
  logic [7:0] bt[$];
  bit   bp[$];
  res_t got[3];
  res_t exp_r[3];
  res_t spec_r;
  res_t zero_r;

  ime_accum_if #(.W_ACC(32), .W_SUM(48), .K_MAX(4096)) if_d ();
  ime_accum_if #(.W_ACC(32), .W_SUM(32), .K_MAX(4096)) if_s ();
  ime_accum_if #(.W_ACC(32), .W_SUM(48), .K_MAX(4))    if_k ();

  assign if_d.in_valid = drv_valid;   assign if_s.in_valid = drv_valid;   assign if_k.in_valid = drv_valid;
  assign if_d.in_partial_acc = drv_part; assign if_s.in_partial_acc = drv_part; assign if_k.in_partial_acc = drv_part;
  assign if_d.in_tuser = drv_tuser;   assign if_s.in_tuser = drv_tuser;   assign if_k.in_tuser = drv_tuser;
  assign if_d.in_last = drv_last;     assign if_s.in_last = drv_last;     assign if_k.in_last = drv_last;
  assign if_d.in_poison = drv_poison; assign if_s.in_poison = drv_poison; assign if_k.in_poison = drv_poison;
  assign if_d.clear = drv_clear;      assign if_s.clear = drv_clear;      assign if_k.clear = drv_clear;
  assign if_d.out_ready = drv_ready;  assign if_s.out_ready = drv_ready;  assign if_k.out_ready = drv_ready;

  ime_accum #(.W_ACC(32), .W_SUM(48), .K_MAX(4096)) u_dut_d (.clk(clk), .rst_n(rst_n), .bus(if_d));
  ime_accum #(.W_ACC(32), .W_SUM(32), .K_MAX(4096)) u_dut_s (.clk(clk), .rst_n(rst_n), .bus(if_s));
  ime_accum #(.W_ACC(32), .W_SUM(48), .K_MAX(4))    u_dut_k (.clk(clk), .rst_n(rst_n), .bus(if_k));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic new_frame();
    bv.delete(); bt.delete(); bp.delete();
  endtask

  task automatic push(input int v, input logic [7:0] t, input bit p);
    bv.push_back(v); bt.push_back(t); bp.push_back(p);
  endtask

  // Reference: sequential saturating sum, then the frame-level status rules.
  task automatic fill_exp();
    for (int d = 0; d < 3; d++) begin
      longint mx, s;
      bit pz, ov, kx;
      int n, cnt;
      mx = (longint'(1) << (WS[d] - 1)) - longint'(1);
      s = 0; pz = 1'b0; ov = 1'b0;
      n = bv.size();
      for (int i = 0; i < n; i++) begin
        if (i == 0) s = longint'(bv[i]);
        else begin
          s = s + longint'(bv[i]);
          if (s > mx) begin s = mx; ov = 1'b1; end
          else if (s < -mx - 1) begin s = -mx - 1; ov = 1'b1; end
        end
        pz = pz | bp[i] | (bt[i] != bt[0]);
      end
      kx = (n > KM[d]);
      pz = pz | kx;
      cnt = kx ? KM[d] : n;
      exp_r[d] = '{1'b1, pz ? 64'd0 : s, cnt, bt[0], pz, ov, kx};
    end
  endtask

  task automatic sample();
    got[0] = '{if_d.out_valid, longint'(if_d.out_result), 32'(if_d.out_count), if_d.out_tuser,
               if_d.out_poison, if_d.out_overflow, if_d.out_k_exceeded};
    got[1] = '{if_s.out_valid, longint'(if_s.out_result), 32'(if_s.out_count), if_s.out_tuser,
               if_s.out_poison, if_s.out_overflow, if_s.out_k_exceeded};
    got[2] = '{if_k.out_valid, longint'(if_k.out_result), 32'(if_k.out_count), if_k.out_tuser,
               if_k.out_poison, if_k.out_overflow, if_k.out_k_exceeded};
  endtask

  task automatic wait_ready();
    int t;
    t = 0;
    while (!if_d.in_ready && t < 20) begin step(); t++; end
    if (!if_d.in_ready) begin
      n_cmp++; n_fail++;
      $display("FAIL ready_timeout in_ready=%0b required=1", if_d.in_ready);
    end
  endtask

  // Sends the queued frame with random idle gaps. The last beat is accepted on the final step.
  task automatic drive_frame();
    for (int i = 0; i < bv.size(); i++) begin
      int unsigned gap;
      gap = $urandom_range(0, 1);
      repeat (gap) step();
      wait_ready();
      drv_valid = 1'b1; drv_part = bv[i]; drv_tuser = bt[i]; drv_poison = bp[i];
      drv_last = (i == bv.size() - 1);
      step();
      drv_valid = 1'b0; drv_last = 1'b0; drv_poison = 1'b0;
    end
  endtask

  task automatic release_result(input int hold);
    repeat (hold) step();
    drv_ready = 1'b1;
    step();
    drv_ready = 1'b0;
  endtask

  task automatic test_reset();
    sample();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (got[d] !== zero_r) begin
        n_fail++; $display("FAIL reset_out dut%0d got=%h required=%h", d, got[d], zero_r);
      end
    end
    n_cmp++;
    if (if_d.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL reset_ready got=%0b required=0", if_d.in_ready);
    end
  endtask

  task automatic test_basic();
    new_frame(); push(10, 8'h21, 0); push(-3, 8'h21, 0); push(5, 8'h21, 0);
    drive_frame(); fill_exp(); sample();
    spec_r = '{1'b1, 64'd12, 32'd3, 8'h21, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got[0] !== spec_r) begin
      n_fail++; $display("FAIL basic_spec got=%h required=%h", got[0], spec_r);
    end
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (got[d] !== exp_r[d]) begin
        n_fail++; $display("FAIL basic dut%0d got=%h required=%h", d, got[d], exp_r[d]);
      end
    end
    release_result(0);
  endtask

  task automatic test_poison();
    new_frame(); push(10, 8'h21, 0); push(20, 8'h21, 1); push(30, 8'h21, 0);
    drive_frame(); sample();
    spec_r = '{1'b1, 64'd0, 32'd3, 8'h21, 1'b1, 1'b0, 1'b0};
    n_cmp++;
    if (got[0] !== spec_r) begin
      n_fail++; $display("FAIL poison_beat got=%h required=%h", got[0], spec_r);
    end
    release_result(1);
    new_frame(); push(1, 8'h21, 0); push(2, 8'h21, 0); push(3, 8'h22, 0);
    drive_frame(); sample();
    n_cmp++;
    if (got[0] !== spec_r) begin
      n_fail++; $display("FAIL poison_tag got=%h required=%h", got[0], spec_r);
    end
    release_result(0);
  endtask

  task automatic test_saturation();
    new_frame(); push(32'h7FFF_FFFF, 8'h10, 0); push(1, 8'h10, 0);
    drive_frame(); fill_exp(); sample();
    spec_r = '{1'b1, 64'h0000_0000_7FFF_FFFF, 32'd2, 8'h10, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got[1] !== spec_r) begin
      n_fail++; $display("FAIL sat_pos got=%h required=%h", got[1], spec_r);
    end
    n_cmp++;
    if (got[0] !== exp_r[0]) begin
      n_fail++; $display("FAIL sat_pos_wide got=%h required=%h", got[0], exp_r[0]);
    end
    release_result(0);
    new_frame(); push(int'(32'h8000_0000), 8'h11, 0); push(-1, 8'h11, 0);
    drive_frame(); fill_exp(); sample();
    spec_r = '{1'b1, 64'hFFFF_FFFF_8000_0000, 32'd2, 8'h11, 1'b0, 1'b1, 1'b0};
    n_cmp++;
    if (got[1] !== spec_r) begin
      n_fail++; $display("FAIL sat_neg got=%h required=%h", got[1], spec_r);
    end
    n_cmp++;
    if (got[0] !== exp_r[0]) begin
      n_fail++; $display("FAIL sat_neg_wide got=%h required=%h", got[0], exp_r[0]);
    end
    release_result(0);
  endtask

  task automatic test_hold();
    new_frame(); push(100, 8'h5A, 0); push(-40, 8'h5A, 0);
    drive_frame(); fill_exp();
    for (int c = 0; c < 5; c++) begin
      sample();
      n_cmp++;
      if ((got[0] !== exp_r[0]) || (if_d.in_ready !== 1'b0)) begin
        n_fail++; $display("FAIL hold_c%0d got=%h rdy=%0b required=%h rdy=0", c, got[0], if_d.in_ready, exp_r[0]);
      end
      step();
    end
    release_result(0);
    sample();
    n_cmp++;
    if ((got[0].vld !== 1'b0) || (if_d.in_ready !== 1'b1)) begin
      n_fail++; $display("FAIL hold_release vld=%0b rdy=%0b required vld=0 rdy=1", got[0].vld, if_d.in_ready);
    end
    new_frame(); push(7, 8'h01, 0);
    drive_frame(); fill_exp(); sample();
    n_cmp++;
    if (got[0] !== exp_r[0]) begin
      n_fail++; $display("FAIL hold_next got=%h required=%h", got[0], exp_r[0]);
    end
    release_result(0);
  endtask

  task automatic test_k_exceeded();
    new_frame();
    for (int i = 0; i < 6; i++) push(i + 1, 8'h3C, 0);
    drive_frame(); fill_exp(); sample();
    spec_r = '{1'b1, 64'd0, 32'd4, 8'h3C, 1'b1, 1'b0, 1'b1};
    n_cmp++;
    if (got[2] !== spec_r) begin
      n_fail++; $display("FAIL kmax got=%h required=%h", got[2], spec_r);
    end
    n_cmp++;
    if (got[0] !== exp_r[0]) begin
      n_fail++; $display("FAIL kmax_default got=%h required=%h", got[0], exp_r[0]);
    end
    release_result(0);
  endtask

  task automatic test_clear();
    wait_ready();
    drv_valid = 1'b1; drv_part = 32'd40; drv_tuser = 8'h44; drv_last = 1'b0;
    step();
    drv_part = 32'd60; drv_last = 1'b1; drv_clear = 1'b1;
    step();
    drv_valid = 1'b0; drv_last = 1'b0; drv_clear = 1'b0;
    repeat (2) begin
      sample();
      n_cmp++;
      if ((got[0].vld !== 1'b0) || (if_d.in_ready !== 1'b1)) begin
        n_fail++; $display("FAIL clear_drop vld=%0b rdy=%0b required vld=0 rdy=1", got[0].vld, if_d.in_ready);
      end
      step();
    end
    new_frame(); push(7, 8'h33, 0);
    drive_frame(); sample();
    spec_r = '{1'b1, 64'd7, 32'd1, 8'h33, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got[0] !== spec_r) begin
      n_fail++; $display("FAIL clear_next got=%h required=%h", got[0], spec_r);
    end
    release_result(0);
  endtask

  task automatic test_reset_mid();
    wait_ready();
    drv_valid = 1'b1; drv_part = 32'd50; drv_tuser = 8'h55; drv_last = 1'b0;
    step();
    drv_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 sample();
    for (int d = 0; d < 3; d++) begin
      n_cmp++;
      if (got[d] !== zero_r) begin
        n_fail++; $display("FAIL rstmid_out dut%0d got=%h required=%h", d, got[d], zero_r);
      end
    end
    n_cmp++;
    if (if_d.in_ready !== 1'b0) begin
      n_fail++; $display("FAIL rstmid_ready got=%0b required=0", if_d.in_ready);
    end
    step();
    rst_n = 1'b1;
    step();
    new_frame(); push(7, 8'h66, 0);
    drive_frame(); sample();
    spec_r = '{1'b1, 64'd7, 32'd1, 8'h66, 1'b0, 1'b0, 1'b0};
    n_cmp++;
    if (got[0] !== spec_r) begin
      n_fail++; $display("FAIL rstmid_next got=%h required=%h", got[0], spec_r);
    end
    release_result(0);
  endtask

  task automatic test_random();
    for (int f = 0; f < 40; f++) begin
      int unsigned len, sel;
      logic [7:0] tag;
      int v;
      new_frame();
      len = $urandom_range(1, 7);
      tag = 8'($urandom);
      for (int unsigned i = 0; i < len; i++) begin
        sel = $urandom_range(0, 3);
        if (sel == 0) v = int'(32'h7FF0_0000 + ($urandom & 32'h000F_FFFF));
        else if (sel == 1) v = int'(32'h8000_0000 + ($urandom & 32'h000F_FFFF));
        else v = int'($urandom);
        push(v, ((i > 0) && ($urandom_range(0, 7) == 0)) ? tag ^ 8'h01 : tag,
             ($urandom_range(0, 9) == 0));
      end
      drive_frame(); fill_exp(); sample();
      for (int d = 0; d < 3; d++) begin
        n_cmp++;
        if (got[d] !== exp_r[d]) begin
          n_fail++; $display("FAIL random f%0d dut%0d got=%h required=%h", f, d, got[d], exp_r[d]);
        end
      end
      release_result($urandom_range(0, 3));
    end
  endtask

  initial begin
    zero_r = '0;
    rst_n = 1'b0;
    drv_valid = 1'b0; drv_last = 1'b0; drv_poison = 1'b0; drv_clear = 1'b0;
    drv_ready = 1'b0; drv_part = 32'd0; drv_tuser = 8'h00;
    repeat (3) step();
    test_reset();
    rst_n = 1'b1;
    step();
    test_basic();
    test_poison();
    test_saturation();
    test_hold();
    test_k_exceeded();
    test_clear();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
